// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl
// Purpose  : Decode-stage branch sequencer. Drives the comparator op select,
//            holds ID on load-use, issues a held redirect to fetch and keeps
//            taken / not-taken statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl #(
    parameter logic [31:0] PC_RST = 32'h0000_0000,
    parameter int          CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic             id_is_jump,
    input  logic [4:0]       id_judge_ctrl,
    input  logic [31:0]      id_target,
    input  logic             src_pending,
    input  logic             cmp_nt,
    input  logic             if_redirect_ready,
    input  logic             pipe_flush,
    output logic [4:0]       judge_ctrl,
    output logic             stall_id,
    output logic             flush_ifid,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [4:0]       r_op;
    logic             r_is_jump;
    logic [31:0]      r_target;
    logic [31:0]      r_redirect_pc;
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_ntaken_cnt;

    logic             w_ctl;
    logic             w_latch;
    logic             w_resolve;
    logic             w_res_jump;
    logic [31:0]      w_res_target;
    logic             w_taken;
    logic             w_commit;

    assign w_ctl    = id_valid & (id_is_branch | id_is_jump);
    assign w_taken  = w_res_jump | ~cmp_nt;
    // A later-stage flush discards the branch: no statistics, no redirect.
    assign w_commit = w_resolve & ~pipe_flush;

    always_comb begin
        w_next_state   = r_state;
        judge_ctrl     = id_judge_ctrl;
        stall_id       = 1'b0;
        flush_ifid     = 1'b0;
        redirect_valid = 1'b0;
        w_latch        = 1'b0;
        w_resolve      = 1'b0;
        w_res_jump     = id_is_jump;
        w_res_target   = id_target;

        case (r_state)
            S_IDLE: begin
                if (w_ctl) begin
                    if (src_pending) begin
                        stall_id     = 1'b1;
                        w_latch      = 1'b1;
                        w_next_state = S_WAIT;
                    end else begin
                        w_resolve = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                judge_ctrl   = r_op;
                stall_id     = src_pending;
                w_res_jump   = r_is_jump;
                w_res_target = r_target;
                w_resolve    = ~src_pending;
            end
            S_REDIR: begin
                // ID holds wrong-path contents here; id_valid is not consulted.
                redirect_valid = 1'b1;
                flush_ifid     = 1'b1;
                if (if_redirect_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (w_resolve) begin
            w_next_state = w_taken ? S_REDIR : S_IDLE;
        end
        if (pipe_flush) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= 5'd0;
            r_is_jump <= 1'b0;
            r_target  <= 32'd0;
        end else if (w_latch) begin
            r_op      <= id_judge_ctrl;
            r_is_jump <= id_is_jump;
            r_target  <= id_target;
        end
    end

    // redirect_pc only moves on a committed taken resolve, so it stays
    // stable for the whole REDIR handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_pc <= PC_RST;
        end else if (w_commit && w_taken) begin
            r_redirect_pc <= w_res_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_taken_cnt  <= '0;
            r_ntaken_cnt <= '0;
        end else if (w_commit) begin
            if (w_taken) begin
                r_taken_cnt  <= r_taken_cnt + c_CNT_ONE;
            end else begin
                r_ntaken_cnt <= r_ntaken_cnt + c_CNT_ONE;
            end
        end
    end

    assign redirect_pc = r_redirect_pc;
    assign taken_cnt   = r_taken_cnt;
    assign ntaken_cnt  = r_ntaken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_redirect_ctrl
// Purpose  : Directed and random stimulus against a transaction-level model
//            of the branch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;

    localparam logic [31:0] c_PC_RST = 32'h1C00_0000;
    localparam int          c_CNT_W  = 4;
    localparam int          c_MOD    = 1 << c_CNT_W;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic              id_is_branch;
    logic              id_is_jump;
    logic [4:0]        id_judge_ctrl;
    logic [31:0]       id_target;
    logic              src_pending;
    logic              cmp_nt;
    logic              if_redirect_ready;
    logic              pipe_flush;
    logic [4:0]        judge_ctrl;
    logic              stall_id;
    logic              flush_ifid;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [c_CNT_W-1:0] taken_cnt;
    logic [c_CNT_W-1:0] ntaken_cnt;

    int n_checks;
    int n_errors;

    // Model: what the sequencer is doing, in transaction terms.
    bit          m_stalled_branch;
    bit          m_redirect_out;
    logic [4:0]  m_op;
    bit          m_jump;
    logic [31:0] m_target;
    logic [31:0] m_pc;
    int          m_taken;
    int          m_ntaken;

    branch_redirect_ctrl #(
        .PC_RST (c_PC_RST),
        .CNT_W  (c_CNT_W)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .id_valid          (id_valid),
        .id_is_branch      (id_is_branch),
        .id_is_jump        (id_is_jump),
        .id_judge_ctrl     (id_judge_ctrl),
        .id_target         (id_target),
        .src_pending       (src_pending),
        .cmp_nt            (cmp_nt),
        .if_redirect_ready (if_redirect_ready),
        .pipe_flush        (pipe_flush),
        .judge_ctrl        (judge_ctrl),
        .stall_id          (stall_id),
        .flush_ifid        (flush_ifid),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .taken_cnt         (taken_cnt),
        .ntaken_cnt        (ntaken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stalled_branch = 1'b0;
        m_redirect_out   = 1'b0;
        m_op             = 5'd0;
        m_jump           = 1'b0;
        m_target         = 32'd0;
        m_pc             = c_PC_RST;
        m_taken          = 0;
        m_ntaken         = 0;
    endtask

    task automatic model_resolve(input bit jump, input logic [31:0] tgt);
        m_stalled_branch = 1'b0;
        if (jump || !cmp_nt) begin
            m_pc           = tgt;
            m_taken        = (m_taken + 1) % c_MOD;
            m_redirect_out = 1'b1;
        end else begin
            m_ntaken = (m_ntaken + 1) % c_MOD;
        end
    endtask

    task automatic model_edge();
        bit ctl;
        ctl = id_valid && (id_is_branch || id_is_jump);
        if (pipe_flush) begin
            m_stalled_branch = 1'b0;
            m_redirect_out   = 1'b0;
        end else if (m_redirect_out) begin
            if (if_redirect_ready) m_redirect_out = 1'b0;
        end else if (m_stalled_branch) begin
            if (!src_pending) model_resolve(m_jump, m_target);
        end else if (ctl) begin
            if (src_pending) begin
                m_stalled_branch = 1'b1;
                m_op             = id_judge_ctrl;
                m_jump           = id_is_jump;
                m_target         = id_target;
            end else begin
                model_resolve(id_is_jump, id_target);
            end
        end
    endtask

    task automatic check_outputs();
        bit ctl;
        ctl = id_valid && (id_is_branch || id_is_jump);
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redirect_out});
        chk("flush_ifid", {31'd0, flush_ifid}, {31'd0, m_redirect_out});
        chk("redirect_pc", redirect_pc, m_pc);
        chk("taken_cnt", {28'd0, taken_cnt}, m_taken);
        chk("ntaken_cnt", {28'd0, ntaken_cnt}, m_ntaken);
        if (m_redirect_out) begin
            chk("stall_redir", {31'd0, stall_id}, 32'd0);
        end else if (m_stalled_branch) begin
            chk("stall_wait", {31'd0, stall_id}, {31'd0, src_pending});
            chk("judge_wait", {27'd0, judge_ctrl}, {27'd0, m_op});
        end else begin
            chk("stall_idle", {31'd0, stall_id}, {31'd0, ctl && src_pending});
            chk("judge_idle", {27'd0, judge_ctrl}, {27'd0, id_judge_ctrl});
        end
    endtask

    // Inputs are already driven; check mid-cycle, then advance the model.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit v, input bit br, input bit jp, input logic [4:0] op,
                         input logic [31:0] tgt, input bit pend, input bit nt,
                         input bit rdy, input bit fl);
        id_valid          = v;
        id_is_branch      = br;
        id_is_jump        = jp;
        id_judge_ctrl     = op;
        id_target         = tgt;
        src_pending       = pend;
        cmp_nt            = nt;
        if_redirect_ready = rdy;
        pipe_flush        = fl;
    endtask

    task automatic idle_in(input bit rdy);
        drive(1'b0, 1'b0, 1'b0, 5'h1F, 32'hDEAD_BEEF, 1'b0, 1'b1, rdy, 1'b0);
    endtask

    initial begin
        logic [31:0] pc_hold;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        idle_in(1'b1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, c_PC_RST);
        chk("rst_judge_pass", {27'd0, judge_ctrl}, 32'h1F);
        @(posedge clk); #1;

        // beq not taken
        drive(1'b1, 1'b1, 1'b0, 5'h0A, 32'h1C00_0100, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        idle_in(1'b1);
        cycle();
        chk("beq_ntaken_cnt", {28'd0, ntaken_cnt}, 32'd1);

        // bne taken with immediate accept
        drive(1'b1, 1'b1, 1'b0, 5'h0B, 32'h1C00_0040, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        idle_in(1'b1);
        cycle();
        cycle();
        chk("bne_taken_cnt", {28'd0, taken_cnt}, 32'd1);
        chk("bne_pc", redirect_pc, 32'h1C00_0040);

        // Load-use: three pending cycles, op changes under the stall
        drive(1'b1, 1'b1, 1'b0, 5'h0C, 32'h1C00_0200, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        id_judge_ctrl = 5'h03;
        cycle();
        cycle();
        src_pending = 1'b0;
        cmp_nt      = 1'b0;
        cycle();
        idle_in(1'b1);
        cycle();
        cycle();

        // jirl with four cycles of fetch backpressure
        drive(1'b1, 1'b0, 1'b1, 5'h00, 32'h1C00_0800, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        idle_in(1'b0);
        pc_hold = redirect_pc;
        repeat (4) cycle();
        chk("bp_pc_stable", redirect_pc, pc_hold);
        if_redirect_ready = 1'b1;
        cycle();
        cycle();

        // pipe_flush in WAIT
        drive(1'b1, 1'b1, 1'b0, 5'h0D, 32'h1C00_0300, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle();
        pipe_flush = 1'b1;
        src_pending = 1'b0;
        cycle();
        idle_in(1'b1);
        cycle();

        // pipe_flush together with ready in REDIR, and flush on a resolve
        drive(1'b1, 1'b1, 1'b0, 5'h0E, 32'h1C00_0400, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        idle_in(1'b1);
        pipe_flush = 1'b1;
        cycle();
        drive(1'b1, 1'b0, 1'b1, 5'h00, 32'h1C00_0500, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle();
        idle_in(1'b1);
        cycle();

        // Async reset mid-REDIR, no clock edge between assert and check
        drive(1'b1, 1'b0, 1'b1, 5'h00, 32'h1C00_0600, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        idle_in(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("arst_flush_ifid", {31'd0, flush_ifid}, 32'd0);
        chk("arst_stall_id", {31'd0, stall_id}, 32'd0);
        chk("arst_redirect_pc", redirect_pc, c_PC_RST);
        chk("arst_taken_cnt", {28'd0, taken_cnt}, 32'd0);
        model_reset();
        @(posedge clk); #1 rst = 1'b0;

        // Counter wrap: 16 taken transfers
        for (int i = 0; i < c_MOD; i++) begin
            drive(1'b1, 1'b0, 1'b1, 5'h00, 32'h1C00_1000 + 32'(i * 4), 1'b0, 1'b1, 1'b1, 1'b0);
            cycle();
            idle_in(1'b1);
            cycle();
        end
        chk("wrap_taken_cnt", {28'd0, taken_cnt}, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            id_valid          = ($urandom_range(0, 9) < 7);
            id_is_branch      = ($urandom_range(0, 1) == 1);
            id_is_jump        = ($urandom_range(0, 3) == 0);
            id_judge_ctrl     = 5'($urandom);
            id_target         = $urandom & 32'hFFFF_FFFC;
            src_pending       = ($urandom_range(0, 9) < 3);
            cmp_nt            = ($urandom_range(0, 1) == 1);
            if_redirect_ready = ($urandom_range(0, 9) < 6);
            pipe_flush        = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Decode-stage branch sequencer for the LoongArch pipeline. It sequences the combinational branch comparator: it drives the comparator's 5-bit op select and stalls ID while the branch source operands are still in flight. It samples the comparator's not-taken flag, then issues a held redirect request to the fetch stage and flushes the wrong-path instruction in IF/ID until fetch accepts. It also keeps taken / not-taken statistics counters.

## Interface
- `PC_RST`, default 32'h0000_0000: reset value of `redirect_pc`.
- `CNT_W`, default 16: width of the statistics counters.

- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `id_valid`, in, 1: the ID stage holds a valid instruction.
- `id_is_branch`, in, 1: conditional branch (beq/bne/blt/bge/bltu/bgeu).
- `id_is_jump`, in, 1: unconditional control transfer (b/bl/jirl).
- `id_judge_ctrl`, in, 5: comparator op code from decode, using the `ALUOp_*` encodings.
- `id_target`, in, 32: computed branch target.
- `src_pending`, in, 1: a needed source is not yet forwardable (a load sits in EX or MEM).
- `cmp_nt`, in, 1: comparator result. 1 means the condition fails (not taken). The comparator's default for unlisted ops is 1.
- `if_redirect_ready`, in, 1: fetch accepts the redirect this cycle.
- `pipe_flush`, in, 1: exception or ertn flush from a later stage.
- `judge_ctrl`, out, 5: op select to the comparator.
- `stall_id`, out, 1: hold the PC and IF/ID registers.
- `flush_ifid`, out, 1: invalidate the IF/ID register.
- `redirect_valid`, out, 1: redirect request to fetch.
- `redirect_pc`, out, 32: redirect target.
- `taken_cnt`, out, CNT_W: count of resolved taken transfers.
- `ntaken_cnt`, out, CNT_W: count of resolved not-taken branches.

## Operation
- Define `ctl = id_valid & (id_is_branch | id_is_jump)`.
- Define `taken = is_jump | ~cmp_nt`. Here `is_jump` is `id_is_jump` in IDLE and the latched copy in WAIT.
- The FSM has three states: IDLE, WAIT and REDIR.
- IDLE:
  - `judge_ctrl = id_judge_ctrl`.
  - If `ctl & src_pending`: latch `id_judge_ctrl`, `id_is_jump` and `id_target`; assert `stall_id`; go to WAIT.
  - If `ctl & ~src_pending`: resolve this cycle.
    - Taken: latch `id_target` into `redirect_pc`, increment `taken_cnt`, go to REDIR.
    - Not taken: increment `ntaken_cnt` and stay in IDLE.
    - `stall_id` stays 0, so the branch itself advances to EX (link write for bl/jirl).
- WAIT:
  - `judge_ctrl` is the latched op and `stall_id = src_pending`.
  - When `src_pending` falls, resolve exactly as in IDLE, using the latched jump flag and target. The next state is REDIR if taken, else IDLE.
- REDIR:
  - `redirect_valid = 1` and `flush_ifid = 1`.
  - `redirect_pc` is held stable.
  - Leave to IDLE on the cycle where `if_redirect_ready = 1`.
  - `id_valid` is ignored, because the ID contents are wrong-path and being flushed.
- `pipe_flush` has the highest priority. It forces the next state to IDLE from any state, with no counter update. The branch is discarded.
- Counters wrap modulo 2^CNT_W and are never saturated.
- `judge_ctrl` outside a branch: in IDLE with `ctl = 0` it passes `id_judge_ctrl` through, so it is a don't-care for the comparator.

## Timing
- Reset values:
  - state = IDLE
  - `redirect_valid = 0`, `flush_ifid = 0`, `stall_id = 0`
  - `redirect_pc = PC_RST`
  - `judge_ctrl = id_judge_ctrl` (combinational)
  - both counters = 0
- `stall_id`, `flush_ifid`, `redirect_valid` and `judge_ctrl` are Moore/Mealy combinational from the state and inputs, as defined above.
- `redirect_pc` and the counters are registered.
- Latency:
  - Resolve cycle to `redirect_valid` high is 1 cycle.
  - The minimum taken-branch penalty is 2 cycles: the resolve cycle plus one REDIR cycle with immediate ready.
- Handshake: once raised, `redirect_valid` and `redirect_pc` must stay stable until `if_redirect_ready` is sampled high. The transfer completes on that edge.
- `if_redirect_ready` held low: stay in REDIR indefinitely with the outputs held.
- Simultaneous `pipe_flush` and `if_redirect_ready` in REDIR: go to IDLE, with no double effect.
- `pipe_flush` in the same cycle as a resolve: the counter does not increment and the state does not enter REDIR.
- Asynchronous `rst` asserted mid-REDIR or mid-WAIT: the outputs reach their reset values immediately, without waiting for a clock.
- A not-taken branch resolved in WAIT releases the stall in the resolve cycle. ID advances that same cycle.

## Test plan
- beq not taken: in IDLE, `src_pending=0`, `cmp_nt=1`. Required: `stall_id` stays 0, `ntaken_cnt` becomes 1, `redirect_valid` never rises.
- bne taken: target 0x1C00_0040, `cmp_nt=0`, `if_redirect_ready=1`. Required: next cycle `redirect_valid=1`, `redirect_pc=0x1C00_0040`, `flush_ifid=1` for exactly 1 cycle; `taken_cnt` becomes 1.
- Load-use: `src_pending=1` for 3 cycles, then 0 with `cmp_nt=0`. Required: `stall_id=1` for exactly 3 cycles; `judge_ctrl` holds the latched op throughout; redirect occurs 1 cycle after the release.
- Fetch backpressure: jirl taken with `if_redirect_ready` low for 4 cycles. Required: `redirect_valid` and `redirect_pc` stable for 5 cycles; return to IDLE after the accept edge.
- `pipe_flush` in REDIR and in WAIT. Required: IDLE next cycle, no counter change, `redirect_valid=0`.
- Counter wrap with CNT_W=4: 16 taken branches. Required: `taken_cnt` returns to 0.
- Async `rst` mid-REDIR. Required: all outputs reach their reset values immediately, before the next clock edge.
